// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the streaming multi-channel 2D convolution.
package conv_pkg;

    typedef enum logic [1:0] {
        BORDER_PASS  = 2'd0,
        BORDER_ZERO  = 2'd1,
        BORDER_CONST = 2'd2
    } border_mode_e;

    localparam int unsigned SAT_MAX_W = 32;

    // Signed accumulator width that cannot overflow for a full kernel of extreme products.
    function automatic int unsigned acc_width(input int unsigned w, input int unsigned kw,
                                              input int unsigned kh, input int unsigned kwid);
        return w + kw + 1 + $clog2(kh * kwid);
    endfunction

    // Round half up by 2^shift, then clamp into the unsigned range [0, 2^w-1].
    function automatic logic [SAT_MAX_W-1:0] sat_round(input logic signed [63:0] acc,
                                                      input logic [4:0]         shift,
                                                      input int unsigned        w);
        logic signed [63:0] rounded;
        logic signed [63:0] max_val;
        max_val = (64'sd1 <<< w) - 64'sd1;
        if (shift == 5'd0) begin
            rounded = acc;
        end else begin
            rounded = (acc + (64'sd1 <<< (shift - 5'd1))) >>> shift;
        end
        if (rounded < 64'sd0) begin
            return '0;
        end
        if (rounded > max_val) begin
            return max_val[SAT_MAX_W-1:0];
        end
        return rounded[SAT_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One channel's row store: each column word holds the previous ROWS rows, newest row in the low bits.
module conv_line_buffer #(
    parameter int unsigned DEPTH = 320,
    parameter int unsigned ROWS  = 2,
    parameter int unsigned W     = 8,
    parameter int unsigned AW    = 9
) (
    input  logic              clk,
    input  logic              en,
    input  logic [AW-1:0]     addr,
    input  logic [W-1:0]      wdata,
    output logic [ROWS*W-1:0] rdata
);

    logic [ROWS*W-1:0] mem [DEPTH];
    logic [ROWS*W-1:0] wword;

    assign rdata = mem[addr];

    // The write pushes the incoming pixel in and ages every stored row by one.
    if (ROWS > 1) begin : g_shift
        assign wword = {rdata[(ROWS-1)*W-1:0], wdata};
    end else begin : g_single
        assign wword = wdata;
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wword;
        end
    end

endmodule

// File: rtl/conv2d_stream.sv
// Stallable 3-stage streaming 2D convolution with border handling and frame sidebands.
// kernel coefficient (r,c) sits at bits [(r*KERNEL_W+c)*KW +: KW]; row 0 is the oldest line.
module conv2d_stream
    import conv_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 320,
    parameter int unsigned IMG_HEIGHT = 240,
    parameter int unsigned CHANNELS   = 3,
    parameter int unsigned KERNEL_H   = 3,
    parameter int unsigned KERNEL_W   = 3,
    parameter int unsigned W          = 8,
    parameter int unsigned KW         = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            x_valid,
    output logic                            x_ready,
    input  logic [CHANNELS*W-1:0]           x_data,
    input  logic                            x_sof,
    output logic                            y_valid,
    input  logic                            y_ready,
    output logic [CHANNELS*W-1:0]           y_data,
    output logic                            y_sof,
    output logic                            y_eol,
    input  logic [KERNEL_H*KERNEL_W*KW-1:0] kernel,
    input  logic [4:0]                      shift,
    input  logic [1:0]                      border_mode,
    input  logic [W-1:0]                    border_const
);

    localparam int unsigned XW      = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned YW      = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned AW      = acc_width(W, KW, KERNEL_H, KERNEL_W);
    localparam int unsigned LB_ROWS = (KERNEL_H > 1) ? KERNEL_H - 1 : 1;
    localparam int unsigned PW      = CHANNELS * W;

    logic          en;
    logic          take;
    logic [XW-1:0] x_pos;
    logic [YW-1:0] y_pos;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic          cur_sof;
    logic          cur_eol;
    logic          cur_win_ok;

    logic [W-1:0]         pix_in [CHANNELS];
    logic [W-1:0]         col    [CHANNELS][KERNEL_H];
    logic signed [KW-1:0] coef   [KERNEL_H][KERNEL_W];

    logic [W-1:0]         win    [CHANNELS][KERNEL_H][KERNEL_W];
    logic [W-1:0]         s1_pix [CHANNELS];
    logic                 s1_valid, s1_sof, s1_eol, s1_border;

    logic signed [AW-1:0] sum    [CHANNELS];
    logic signed [AW-1:0] s2_acc [CHANNELS];
    logic [W-1:0]         s2_pix [CHANNELS];
    logic                 s2_valid, s2_sof, s2_eol, s2_border;

    logic [W-1:0]         lane   [CHANNELS];
    logic [PW-1:0]        y_next;

    assign en      = ~y_valid | y_ready;
    assign x_ready = en;
    assign take    = x_valid & en;

    // An accepted sof pixel is (0,0) regardless of where the counters were.
    assign cur_x      = x_sof ? '0 : x_pos;
    assign cur_y      = x_sof ? '0 : y_pos;
    assign cur_sof    = (cur_x == '0) && (cur_y == '0);
    assign cur_eol    = (cur_x == XW'(IMG_WIDTH - 1));
    assign cur_win_ok = (cur_x >= XW'(KERNEL_W - 1)) && (cur_y >= YW'(KERNEL_H - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_pos <= '0;
            y_pos <= '0;
        end else if (take) begin
            if (cur_eol) begin
                x_pos <= '0;
                y_pos <= (cur_y == YW'(IMG_HEIGHT - 1)) ? '0 : cur_y + YW'(1);
            end else begin
                x_pos <= cur_x + XW'(1);
                y_pos <= cur_y;
            end
        end
    end

    for (genvar r = 0; r < KERNEL_H; r++) begin : g_coef_r
        for (genvar c = 0; c < KERNEL_W; c++) begin : g_coef_c
            assign coef[r][c] = kernel[(r*KERNEL_W + c)*KW +: KW];
        end
    end

    // Column entering the window: stored rows on top, the live pixel at the bottom.
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [LB_ROWS*W-1:0] lb_rd;

        assign pix_in[ch] = x_data[ch*W +: W];

        if (KERNEL_H > 1) begin : g_lb
            conv_line_buffer #(
                .DEPTH (IMG_WIDTH),
                .ROWS  (LB_ROWS),
                .W     (W),
                .AW    (XW)
            ) u_lb (
                .clk   (clk),
                .en    (take),
                .addr  (cur_x),
                .wdata (pix_in[ch]),
                .rdata (lb_rd)
            );
        end else begin : g_no_lb
            assign lb_rd = '0;
        end

        for (genvar r = 0; r < KERNEL_H; r++) begin : g_row
            if (r == KERNEL_H - 1) begin : g_live
                assign col[ch][r] = pix_in[ch];
            end else begin : g_stored
                assign col[ch][r] = lb_rd[(KERNEL_H-2-r)*W +: W];
            end
        end

        assign y_next[ch*W +: W] = lane[ch];
    end

    // Datapath registers carry no reset; their validity travels in the control stages.
    always_ff @(posedge clk) begin
        if (take) begin
            for (int ch = 0; ch < int'(CHANNELS); ch++) begin
                for (int r = 0; r < int'(KERNEL_H); r++) begin
                    for (int c = 0; c < int'(KERNEL_W) - 1; c++) begin
                        win[ch][r][c] <= win[ch][r][c+1];
                    end
                    win[ch][r][KERNEL_W-1] <= col[ch][r];
                end
                s1_pix[ch] <= pix_in[ch];
            end
        end
        if (en) begin
            for (int ch = 0; ch < int'(CHANNELS); ch++) begin
                s2_acc[ch] <= sum[ch];
                s2_pix[ch] <= s1_pix[ch];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sof    <= 1'b0;
            s1_eol    <= 1'b0;
            s1_border <= 1'b0;
            s2_valid  <= 1'b0;
            s2_sof    <= 1'b0;
            s2_eol    <= 1'b0;
            s2_border <= 1'b0;
            y_valid   <= 1'b0;
            y_sof     <= 1'b0;
            y_eol     <= 1'b0;
            y_data    <= '0;
        end else if (en) begin
            s1_valid  <= x_valid;
            s1_sof    <= cur_sof;
            s1_eol    <= cur_eol;
            s1_border <= ~cur_win_ok;
            s2_valid  <= s1_valid;
            s2_sof    <= s1_sof;
            s2_eol    <= s1_eol;
            s2_border <= s1_border;
            y_valid   <= s2_valid;
            y_sof     <= s2_sof;
            y_eol     <= s2_eol;
            y_data    <= y_next;
        end
    end

    // Zero-extended pixel times signed coefficient, summed over the whole window.
    always_comb begin
        for (int ch = 0; ch < int'(CHANNELS); ch++) begin
            sum[ch] = '0;
            for (int r = 0; r < int'(KERNEL_H); r++) begin
                for (int c = 0; c < int'(KERNEL_W); c++) begin
                    sum[ch] = sum[ch] + AW'($signed({1'b0, win[ch][r][c]})) * AW'(coef[r][c]);
                end
            end
        end
    end

    always_comb begin
        for (int ch = 0; ch < int'(CHANNELS); ch++) begin
            lane[ch] = W'(sat_round(64'(s2_acc[ch]), shift, W));
            if (s2_border) begin
                case (border_mode_e'(border_mode))
                    BORDER_ZERO:  lane[ch] = '0;
                    BORDER_CONST: lane[ch] = border_const;
                    default:      lane[ch] = s2_pix[ch];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv2d_stream.sv
// Bench for conv2d_stream: directed and randomized frames checked against a direct-formula model.
`timescale 1ns/1ps
module tb_conv2d_stream;

    localparam int IMG_W = 16;
    localparam int IMG_H = 12;
    localparam int CH    = 3;
    localparam int KH    = 3;
    localparam int KWID  = 3;
    localparam int W     = 8;
    localparam int KW    = 8;
    localparam int PW    = CH * W;
    localparam int NPIX  = IMG_W * IMG_H;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              x_valid;
    logic              x_ready;
    logic [PW-1:0]     x_data;
    logic              x_sof;
    logic              y_valid;
    logic              y_ready;
    logic [PW-1:0]     y_data;
    logic              y_sof;
    logic              y_eol;
    logic [KH*KWID*KW-1:0] kernel;
    logic [4:0]        shift;
    logic [1:0]        border_mode;
    logic [W-1:0]      border_const;

    always #5 clk = ~clk;

    conv2d_stream #(
        .IMG_WIDTH  (IMG_W),
        .IMG_HEIGHT (IMG_H),
        .CHANNELS   (CH),
        .KERNEL_H   (KH),
        .KERNEL_W   (KWID),
        .W          (W),
        .KW         (KW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .x_valid      (x_valid),
        .x_ready      (x_ready),
        .x_data       (x_data),
        .x_sof        (x_sof),
        .y_valid      (y_valid),
        .y_ready      (y_ready),
        .y_data       (y_data),
        .y_sof        (y_sof),
        .y_eol        (y_eol),
        .kernel       (kernel),
        .shift        (shift),
        .border_mode  (border_mode),
        .border_const (border_const)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    int img [CH][IMG_H][IMG_W];
    int kc  [KH][KWID];
    int m_shift;
    int m_mode;
    int m_const;

    logic [PW-1:0] seq_data[$];
    bit            seq_sof[$];
    logic [PW-1:0] seq_exp[$];
    bit            seq_esof[$];
    bit            seq_eeol[$];
    bit            seq_lat[$];

    task automatic apply_cfg();
        for (int r = 0; r < KH; r++)
            for (int c = 0; c < KWID; c++)
                kernel[(r*KWID + c)*KW +: KW] = KW'(kc[r][c]);
        shift        = 5'(m_shift);
        border_mode  = 2'(m_mode);
        border_const = W'(m_const);
    endtask

    task automatic fill_random();
        for (int ch = 0; ch < CH; ch++)
            for (int y = 0; y < IMG_H; y++)
                for (int x = 0; x < IMG_W; x++)
                    img[ch][y][x] = int'($urandom_range(255));
    endtask

    task automatic random_kernel();
        for (int r = 0; r < KH; r++)
            for (int c = 0; c < KWID; c++)
                kc[r][c] = int'($urandom_range(60)) - 20;
    endtask

    function automatic longint floor_div(input longint a, input longint d);
        longint q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Window whose bottom-right pixel is (x,y); rows/columns before it are outside the frame otherwise.
    function automatic int model(input int ch, input int x, input int y);
        longint acc;
        longint d;
        longint top;
        if (x < KWID - 1 || y < KH - 1) begin
            if (m_mode == 1) return 0;
            if (m_mode == 2) return m_const;
            return img[ch][y][x];
        end
        acc = 0;
        for (int r = 0; r < KH; r++)
            for (int c = 0; c < KWID; c++)
                acc += longint'(kc[r][c]) * longint'(img[ch][y - (KH - 1) + r][x - (KWID - 1) + c]);
        if (m_shift > 0) begin
            d   = longint'(2) ** m_shift;
            acc = floor_div(acc + d / 2, d);
        end
        top = (longint'(1) << W) - 1;
        if (acc < 0) return 0;
        if (acc > top) return int'(top);
        return int'(acc);
    endfunction

    task automatic add_frame(input int npix, input bit lat_first);
        for (int i = 0; i < npix; i++) begin
            int x;
            int y;
            logic [PW-1:0] d;
            logic [PW-1:0] e;
            x = i % IMG_W;
            y = (i / IMG_W) % IMG_H;
            for (int ch = 0; ch < CH; ch++) begin
                d[ch*W +: W] = W'(img[ch][y][x]);
                e[ch*W +: W] = W'(model(ch, x, y));
            end
            seq_data.push_back(d);
            seq_sof.push_back(i == 0);
            seq_exp.push_back(e);
            seq_esof.push_back(x == 0 && y == 0);
            seq_eeol.push_back(x == IMG_W - 1);
            seq_lat.push_back(lat_first && i == 0);
        end
    endtask

    task automatic run_seq(input int ready_pct, input int valid_pct, input string tag);
        logic [PW-1:0] eq_data[$];
        bit            eq_sof[$];
        bit            eq_eol[$];
        bit            eq_lat[$];
        int            eq_cyc[$];
        int            n;
        int            sent;
        int            budget;
        int            nout;
        int            nsof;
        int            neol;
        int            esof;
        int            eeol;
        bit            stall;
        logic [PW-1:0] h_data;
        logic          h_sof;
        logic          h_eol;
        n = seq_data.size();
        sent = 0; nout = 0; nsof = 0; neol = 0; esof = 0; eeol = 0; stall = 1'b0;
        h_data = '0; h_sof = 1'b0; h_eol = 1'b0;
        budget = 20 * n + 100;
        foreach (seq_esof[i]) begin
            esof += int'(seq_esof[i]);
            eeol += int'(seq_eeol[i]);
        end
        while ((sent < n || eq_data.size() != 0) && budget > 0) begin
            @(negedge clk);
            x_valid = (sent < n) && (int'($urandom_range(99)) < valid_pct);
            x_data  = x_valid ? seq_data[sent] : PW'($urandom);
            x_sof   = x_valid ? seq_sof[sent] : 1'($urandom_range(1));
            y_ready = (int'($urandom_range(99)) < ready_pct);
            #1;
            if (stall) begin
                checks++;
                assert (y_valid === 1'b1 && y_data === h_data && y_sof === h_sof && y_eol === h_eol)
                else begin
                    errors++;
                    $error("FAIL %s hold: valid=%b data=%h sof=%b eol=%b required valid=1 data=%h sof=%b eol=%b",
                           tag, y_valid, y_data, y_sof, y_eol, h_data, h_sof, h_eol);
                end
            end
            checks++;
            assert (x_ready === (~y_valid | y_ready))
            else begin
                errors++;
                $error("FAIL %s x_ready: got %b required %b", tag, x_ready, ~y_valid | y_ready);
            end
            if (y_valid === 1'b1 && y_ready === 1'b1) begin
                if (eq_data.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL %s extra_output: got data=%h required no output", tag, y_data);
                end else begin
                    logic [PW-1:0] ed;
                    bit es;
                    bit ee;
                    bit el;
                    int ec;
                    ed = eq_data.pop_front();
                    es = eq_sof.pop_front();
                    ee = eq_eol.pop_front();
                    el = eq_lat.pop_front();
                    ec = eq_cyc.pop_front();
                    checks++;
                    assert (y_data === ed && y_sof === es && y_eol === ee)
                    else begin
                        errors++;
                        $error("FAIL %s out[%0d]: got data=%h sof=%b eol=%b required data=%h sof=%b eol=%b",
                               tag, nout, y_data, y_sof, y_eol, ed, es, ee);
                    end
                    if (el) begin
                        checks++;
                        assert (cycle - ec === 3)
                        else begin
                            errors++;
                            $error("FAIL %s latency: got %0d required 3", tag, cycle - ec);
                        end
                    end
                    nout++;
                    nsof += int'(y_sof);
                    neol += int'(y_eol);
                end
            end
            if (x_valid === 1'b1 && x_ready === 1'b1) begin
                eq_data.push_back(seq_exp[sent]);
                eq_sof.push_back(seq_esof[sent]);
                eq_eol.push_back(seq_eeol[sent]);
                eq_lat.push_back(seq_lat[sent]);
                eq_cyc.push_back(cycle);
                sent++;
            end
            stall  = (y_valid === 1'b1) && (y_ready === 1'b0);
            h_data = y_data;
            h_sof  = y_sof;
            h_eol  = y_eol;
            cycle++;
            budget--;
        end
        @(negedge clk);
        x_valid = 1'b0;
        x_sof   = 1'b0;
        y_ready = 1'b1;
        checks++;
        assert (budget > 0)
        else begin
            errors++;
            $error("FAIL %s timeout: got sent=%0d pending=%0d required sent=%0d pending=0",
                   tag, sent, eq_data.size(), n);
        end
        checks++;
        assert (nout === n && nsof === esof && neol === eeol)
        else begin
            errors++;
            $error("FAIL %s counts: got out=%0d sof=%0d eol=%0d required out=%0d sof=%0d eol=%0d",
                   tag, nout, nsof, neol, n, esof, eeol);
        end
        seq_data.delete(); seq_sof.delete(); seq_exp.delete();
        seq_esof.delete(); seq_eeol.delete(); seq_lat.delete();
    endtask

    initial begin
        rst_n = 1'b0; x_valid = 1'b0; x_data = '0; x_sof = 1'b0; y_ready = 1'b0;
        kernel = '0; shift = '0; border_mode = '0; border_const = '0;
        m_shift = 0; m_mode = 0; m_const = 0;

        #12;
        checks++;
        assert (y_valid === 1'b0 && y_data === '0 && y_sof === 1'b0 && y_eol === 1'b0 && x_ready === 1'b1)
        else begin
            errors++;
            $error("FAIL reset_state: got valid=%b data=%h sof=%b eol=%b ready=%b required 0/0/0/0/1",
                   y_valid, y_data, y_sof, y_eol, x_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Identity kernel on a ramp image, shift 0.
        foreach (kc[r, c]) kc[r][c] = (r == 1 && c == 1) ? 1 : 0;
        m_shift = 0; m_mode = 0; m_const = 0;
        apply_cfg();
        for (int ch = 0; ch < CH; ch++)
            for (int y = 0; y < IMG_H; y++)
                for (int x = 0; x < IMG_W; x++)
                    img[ch][y][x] = (x + y + 40 * ch) % 256;
        add_frame(NPIX, 1'b1);
        run_seq(100, 100, "identity");

        // Box blur on constant 200 with constant border fill.
        foreach (kc[r, c]) kc[r][c] = 1;
        m_shift = 3; m_mode = 2; m_const = 7;
        apply_cfg();
        foreach (img[ch, y, x]) img[ch][y][x] = 200;
        add_frame(NPIX, 1'b0);
        run_seq(100, 70, "box");

        // Laplacian on a single bright pixel: clamps both ways.
        foreach (kc[r, c]) kc[r][c] = (r == 1 && c == 1) ? 8 : -1;
        m_shift = 0; m_mode = 1; m_const = 0;
        apply_cfg();
        foreach (img[ch, y, x]) img[ch][y][x] = 0;
        for (int ch = 0; ch < CH; ch++) img[ch][5][5] = 255;
        add_frame(NPIX, 1'b0);
        run_seq(70, 100, "laplace");

        // Random kernels, shifts and border modes with random backpressure.
        for (int f = 0; f < 3; f++) begin
            random_kernel();
            m_shift = int'($urandom_range(7, 3));
            m_mode  = int'($urandom_range(3));
            m_const = int'($urandom_range(255));
            apply_cfg();
            fill_random();
            add_frame(NPIX, 1'b0);
            fill_random();
            add_frame(NPIX, 1'b0);
            run_seq(50, 100, "random");
        end

        // Early sof after a partial frame resynchronises the counters.
        random_kernel();
        m_shift = 5; m_mode = 0; m_const = 0;
        apply_cfg();
        fill_random();
        add_frame(100, 1'b0);
        fill_random();
        add_frame(NPIX, 1'b1);
        run_seq(100, 100, "early_sof");

        // Asynchronous reset in the middle of a line.
        @(negedge clk);
        y_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            x_valid = 1'b1;
            x_sof   = (i == 0);
            x_data  = PW'($urandom);
            @(negedge clk);
        end
        checks++;
        assert (y_valid === 1'b1)
        else begin
            errors++;
            $error("FAIL pre_reset_valid: got %b required 1", y_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        assert (y_valid === 1'b0 && y_data === '0 && y_sof === 1'b0 && y_eol === 1'b0 && x_ready === 1'b1)
        else begin
            errors++;
            $error("FAIL async_reset: got valid=%b data=%h sof=%b eol=%b ready=%b required 0/0/0/0/1",
                   y_valid, y_data, y_sof, y_eol, x_ready);
        end
        x_valid = 1'b0;
        x_sof   = 1'b0;
        y_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        assert (x_ready === 1'b1 && y_valid === 1'b0)
        else begin
            errors++;
            $error("FAIL post_reset: got ready=%b valid=%b required ready=1 valid=0", x_ready, y_valid);
        end
        random_kernel();
        m_shift = 4; m_mode = 0; m_const = 0;
        apply_cfg();
        fill_random();
        add_frame(NPIX, 1'b0);
        run_seq(60, 90, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
